sweep_data_ram: RTL and testbench

//  Parametrised single-clock data RAM for the processor datapath. Adds lane write masks, a configurable

---
 rtl/data_ram_pkg.sv | 19 +
 rtl/data_ram_rd_pipe.sv | 46 ++++
 rtl/sweep_data_ram.sv | 158 +++++++++++++++
 tb/tb_sweep_data_ram.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared state encodings and helpers for the sweep data RAM.
// Lane parity storage is built only when PARITY_EN is defined.
package data_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_IDLE  = 2'd2
  } ramState_e;

  localparam int RD_LAT_MAX = 4;

  // Even parity: the stored bit makes the lane plus parity hold an even count of ones.
  // Zero-extension of narrower lanes leaves the result unchanged.
  function automatic logic lane_parity(input logic [63:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/data_ram_rd_pipe.sv
// Read-return pipeline: DEPTH stages of {valid, data, perr}; data/perr move only with a valid,
// so the last stage holds the most recent result while no new one arrives.
module data_ram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  input  logic              inPerr,
  output logic              outValid,
  output logic [DATA_W-1:0] outData,
  output logic              outPerr
);

  logic [DEPTH-1:0]             validReg;
  logic [DEPTH-1:0]             perrReg;
  logic [DEPTH-1:0][DATA_W-1:0] dataReg;

  always_ff @(negedge clk) begin
    if (!clr) begin
      validReg <= '0;
      perrReg  <= '0;
      dataReg  <= '0;
    end else begin
      validReg[0] <= inValid;
      if (inValid) begin
        dataReg[0] <= inData;
        perrReg[0] <= inPerr;
      end
      for (int i = 1; i < DEPTH; i++) begin
        validReg[i] <= validReg[i-1];
        if (validReg[i-1]) begin
          dataReg[i] <= dataReg[i-1];
          perrReg[i] <= perrReg[i-1];
        end
      end
    end
  end

  assign outValid = validReg[DEPTH-1];
  assign outData  = dataReg[DEPTH-1];
  assign outPerr  = perrReg[DEPTH-1];

endmodule

// File: rtl/sweep_data_ram.sv
// Single-clock data RAM with lane write masks, pipelined reads and a counter-driven fill sweep.
// Define PARITY_EN to add per-lane even parity, the parInject test input and rdParityErr checking.
module sweep_data_ram
  import data_ram_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                LANE_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] FILL   = '1
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       clrStart,
  input  logic                       wrEn,
  input  logic [ADDR_W-1:0]          wrAddr,
  input  logic [DATA_W/LANE_W-1:0]   wrMask,
  input  logic [DATA_W-1:0]          wrData,
`ifdef PARITY_EN
  input  logic                       parInject,
`endif
  input  logic                       rdReq,
  input  logic [ADDR_W-1:0]          rdAddr,
  output logic                       rdValid,
  output logic [DATA_W-1:0]          rdData,
  output logic                       rdParityErr,
  output logic                       busy
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LAT   = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  ramState_e         stateReg;
  logic [ADDR_W-1:0] cntReg;
  logic              busyReg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idleAccept;
  logic              wrGo;
  logic              rdGo;
  logic [ADDR_W-1:0] wrAddrEff;
  logic [DATA_W-1:0] wrDataEff;
  logic [LANES-1:0]  wrMaskEff;
  logic [DATA_W-1:0] rdWord;
  logic              rdPerr;

  // clrStart outranks any write or read presented on the same edge.
  assign idleAccept = (stateReg == ST_IDLE) && !clrStart;
  assign rdGo       = idleAccept && rdReq;
  assign rdWord     = mem[rdAddr];

  always_comb begin
    wrGo      = 1'b0;
    wrAddrEff = wrAddr;
    wrDataEff = wrData;
    wrMaskEff = wrMask;
    if (stateReg == ST_SWEEP) begin
      wrGo      = 1'b1;
      wrAddrEff = cntReg;
      wrDataEff = FILL;
      wrMaskEff = '1;
    end else if (idleAccept) begin
      wrGo = wrEn;
    end
  end

  always_ff @(negedge clk) begin
    if (!clr) begin
      stateReg <= ST_INIT;
      cntReg   <= '0;
      busyReg  <= 1'b1;
    end else begin
      case (stateReg)
        ST_INIT: stateReg <= ST_SWEEP;
        ST_SWEEP: begin
          cntReg <= cntReg + 1'b1;
          if (cntReg == LAST_ADDR) begin
            stateReg <= ST_IDLE;
            busyReg  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clrStart) begin
            stateReg <= ST_SWEEP;
            cntReg   <= '0;
            busyReg  <= 1'b1;
          end
        end
        default: begin
          stateReg <= ST_INIT;
          cntReg   <= '0;
          busyReg  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PARITY_EN
  logic [LANES-1:0] memPar [DEPTH];
  logic [LANES-1:0] wrPar;
  logic [LANES-1:0] rdPar;

  for (genvar gi = 0; gi < LANES; gi++) begin : gLanePar
    if (gi == 0) begin : gInject
      assign wrPar[gi] = lane_parity(64'(wrDataEff[gi*LANE_W +: LANE_W]))
                         ^ (parInject && (stateReg == ST_IDLE));
    end else begin : gPlain
      assign wrPar[gi] = lane_parity(64'(wrDataEff[gi*LANE_W +: LANE_W]));
    end
    assign rdPar[gi] = lane_parity(64'(rdWord[gi*LANE_W +: LANE_W]));
  end

  assign rdPerr = |(rdPar ^ memPar[rdAddr]);

  always_ff @(negedge clk) begin
    if (clr && wrGo) begin
      for (int k = 0; k < LANES; k++) begin
        if (wrMaskEff[k]) begin
          mem[wrAddrEff][k*LANE_W +: LANE_W] <= wrDataEff[k*LANE_W +: LANE_W];
          memPar[wrAddrEff][k]               <= wrPar[k];
        end
      end
    end
  end
`else
  assign rdPerr = 1'b0;

  always_ff @(negedge clk) begin
    if (clr && wrGo) begin
      for (int k = 0; k < LANES; k++) begin
        if (wrMaskEff[k]) begin
          mem[wrAddrEff][k*LANE_W +: LANE_W] <= wrDataEff[k*LANE_W +: LANE_W];
        end
      end
    end
  end
`endif

  data_ram_rd_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (LAT)
  ) uRdPipe (
    .clk      (clk),
    .clr      (clr),
    .inValid  (rdGo),
    .inData   (rdWord),
    .inPerr   (rdPerr),
    .outValid (rdValid),
    .outData  (rdData),
    .outPerr  (rdParityErr)
  );

  assign busy = busyReg;

endmodule

// File: tb/tb_sweep_data_ram.sv
// Randomised and directed bench for sweep_data_ram against a behavioural model of the RAM.
// Build with PARITY_EN defined to also exercise parInject and rdParityErr.
module tb_sweep_data_ram;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          clrStart = 1'b0;
  logic          wrEn = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [1:0]    wrMask = '0;
  logic [DW-1:0] wrData = '0;
  logic          rdReq = 1'b0;
  logic [AW-1:0] rdAddr = '0;
`ifdef PARITY_EN
  logic          parInject = 1'b0;
`endif
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic          rdParityErr;
  logic          busy;

  int checks = 0;
  int errors = 0;

  sweep_data_ram #(
    .DATA_W (DW),
    .LANE_W (8),
    .ADDR_W (AW),
    .RD_LAT (LAT)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .clrStart    (clrStart),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrMask      (wrMask),
    .wrData      (wrData),
`ifdef PARITY_EN
    .parInject   (parInject),
`endif
    .rdReq       (rdReq),
    .rdAddr      (rdAddr),
    .rdValid     (rdValid),
    .rdData      (rdData),
    .rdParityErr (rdParityErr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, per-lane corrupt flags, sweep progress and a
  // queue of promised read results keyed by the edge on which they must appear.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          perr;
  } rdResult_t;

  logic [DW-1:0] mdlMem [DEPTH];
  logic [1:0]    mdlBad [DEPTH];
  rdResult_t     pend[$];
  int            edgeNo = 0;
  int            sweepLeft = 0;
  bit            inInit = 1'b0;
  bit            modelOn = 1'b0;
  logic          expValid = 1'b0;
  logic          expPerr = 1'b0;
  logic          expBusy = 1'b1;
  logic [DW-1:0] expData = '0;

  always @(negedge clk) begin
    rdResult_t r;
    edgeNo++;
    if (!clr) begin
      modelOn   = 1'b1;
      inInit    = 1'b1;
      sweepLeft = 0;
      pend.delete();
      expValid  = 1'b0;
      expData   = '0;
      expPerr   = 1'b0;
    end else if (modelOn) begin
      if (inInit) begin
        inInit    = 1'b0;
        sweepLeft = DEPTH;
      end else if (sweepLeft > 0) begin
        mdlMem[DEPTH-sweepLeft] = 16'hFFFF;
        mdlBad[DEPTH-sweepLeft] = 2'b00;
        sweepLeft--;
      end else if (clrStart) begin
        sweepLeft = DEPTH;
      end else begin
        if (rdReq) begin
          r.due  = edgeNo + LAT - 1;
          r.data = mdlMem[rdAddr];
          r.perr = |mdlBad[rdAddr];
          pend.push_back(r);
        end
        if (wrEn) begin
          for (int k = 0; k < 2; k++) begin
            if (wrMask[k]) begin
              mdlMem[wrAddr][k*8 +: 8] = wrData[k*8 +: 8];
              mdlBad[wrAddr][k] = 1'b0;
`ifdef PARITY_EN
              if (k == 0) mdlBad[wrAddr][k] = parInject;
`endif
            end
          end
        end
      end
      expValid = 1'b0;
      if (pend.size() > 0 && pend[0].due == edgeNo) begin
        r        = pend.pop_front();
        expValid = 1'b1;
        expData  = r.data;
        expPerr  = r.perr;
      end
    end
    expBusy = inInit || (sweepLeft > 0);
  end

  // Outputs change on the falling edge; compare them on the rising edge.
  always @(posedge clk) begin
    if (modelOn) begin
      check("busy", busy, expBusy);
      check("rdValid", rdValid, expValid);
      check("rdData", rdData, expData);
      check("rdParityErr", rdParityErr, expPerr);
    end
  end

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
    @(posedge clk);
    wrEn = 1'b1; wrAddr = a; wrData = d; wrMask = m;
    @(posedge clk);
    wrEn = 1'b0;
  endtask

  // Single read with a literal expectation; optionally a same-edge write to the same address.
  task automatic litRead(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] want,
                         input logic wantPerr, input bit wrToo, input logic [DW-1:0] wd);
    bit got = 1'b0;
    @(posedge clk);
    rdReq = 1'b1; rdAddr = a;
    if (wrToo) begin
      wrEn = 1'b1; wrAddr = a; wrData = wd; wrMask = 2'b11;
    end
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk);
      if (k == 1) begin
        rdReq = 1'b0; wrEn = 1'b0;
      end
      if (rdValid) begin
        got = 1'b1;
        check(nm, rdData, want);
        check({nm, "_perr"}, rdParityErr, wantPerr);
        check({nm, "_latency"}, k, LAT);
      end
    end
    if (!got) check({nm, "_timeout"}, 0, 1);
  endtask

  // Counts rising edges with busy high, starting one edge after the triggering drive.
  task automatic countBusy(input string nm, input int want);
    int n = 0;
    @(posedge clk);
    clrStart = 1'b0; wrEn = 1'b0; rdReq = 1'b0;
    while (busy && n < 600) begin
      n++;
      @(posedge clk);
    end
    check(nm, n, want);
  endtask

  initial begin
    // Reset, then the power-on sweep.
    repeat (3) @(posedge clk);
    clr = 1'b1;
    countBusy("busy_initial_sweep", 256);

    // Every location holds the fill word; back-to-back reads across the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      rdReq = 1'b1; rdAddr = AW'(i);
    end
    @(posedge clk);
    rdReq = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    litRead("fill_addr0", 8'd0, 16'hFFFF, 1'b0, 1'b0, '0);
    litRead("fill_addr255", 8'd255, 16'hFFFF, 1'b0, 1'b0, '0);

    // Masked lane writes.
    doWrite(8'd5, 16'h1234, 2'b11);
    doWrite(8'd5, 16'hAB00, 2'b10);
    litRead("mask_merge", 8'd5, 16'hAB34, 1'b0, 1'b0, '0);
    doWrite(8'd6, 16'h5678, 2'b00);
    litRead("mask_none", 8'd6, 16'hFFFF, 1'b0, 1'b0, '0);

    // Back-to-back reads return in order with fixed latency.
    doWrite(8'd1, 16'h1111, 2'b11);
    doWrite(8'd2, 16'h2222, 2'b11);
    doWrite(8'd3, 16'h3333, 2'b11);
    @(posedge clk); rdReq = 1'b1; rdAddr = 8'd1;
    @(posedge clk); rdAddr = 8'd2;
    @(posedge clk); rdAddr = 8'd3;
    @(posedge clk); rdReq = 1'b0;
    repeat (LAT - 3) @(posedge clk);
    check("b2b_valid0", rdValid, 1'b1); check("b2b_data0", rdData, 16'h1111);
    @(posedge clk);
    check("b2b_valid1", rdValid, 1'b1); check("b2b_data1", rdData, 16'h2222);
    @(posedge clk);
    check("b2b_valid2", rdValid, 1'b1); check("b2b_data2", rdData, 16'h3333);
    @(posedge clk);
    check("b2b_done", rdValid, 1'b0); check("b2b_hold", rdData, 16'h3333);

    // Read-first on a same-address collision.
    litRead("collide_old", 8'd7, 16'hFFFF, 1'b0, 1'b1, 16'h0F0F);
    litRead("collide_new", 8'd7, 16'h0F0F, 1'b0, 1'b0, '0);

    // clrStart wins over a same-edge write; then a sweep aborted by reset.
    @(posedge clk);
    clrStart = 1'b1; wrEn = 1'b1; wrAddr = 8'd9; wrData = 16'h5555; wrMask = 2'b11;
    countBusy("busy_runtime_sweep", 256);
    litRead("clrstart_drops_write", 8'd9, 16'hFFFF, 1'b0, 1'b0, '0);
    litRead("sweep_clears_addr5", 8'd5, 16'hFFFF, 1'b0, 1'b0, '0);
    @(posedge clk); clrStart = 1'b1;
    @(posedge clk); clrStart = 1'b0;
    repeat (100) @(posedge clk);
    check("busy_mid_sweep", busy, 1'b1);
    clr = 1'b0;
    @(posedge clk);
    clr = 1'b1;
    countBusy("busy_after_abort", 256);

`ifdef PARITY_EN
    parInject = 1'b1;
    doWrite(8'd4, 16'h00C3, 2'b11);
    parInject = 1'b0;
    litRead("parity_injected", 8'd4, 16'h00C3, 1'b1, 1'b0, '0);
    doWrite(8'd4, 16'h00C3, 2'b11);
    litRead("parity_clean", 8'd4, 16'h00C3, 1'b0, 1'b0, '0);
`endif

    // Random traffic on a small address window so collisions are common.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      clr      = ($urandom_range(0, 799) != 0);
      clrStart = ($urandom_range(0, 499) == 0);
      wrEn     = 1'($urandom_range(0, 1));
      rdReq    = 1'($urandom_range(0, 1));
      wrAddr   = AW'($urandom_range(0, 15));
      rdAddr   = AW'($urandom_range(0, 15));
      wrMask   = 2'($urandom);
      wrData   = DW'($urandom);
`ifdef PARITY_EN
      parInject = ($urandom_range(0, 3) == 0);
`endif
    end
    @(posedge clk);
    clr = 1'b1; clrStart = 1'b0; wrEn = 1'b0; rdReq = 1'b0;
`ifdef PARITY_EN
    parInject = 1'b0;
`endif
    repeat (LAT + 2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
